// File: rtl/rptr_handler_pkg.sv
// rptr_handler_pkg: shared async-FIFO pointer width, depth and Gray/binary helpers
package rptr_handler_pkg;
   localparam int PTR_WIDTH_DEF = 3;
   localparam int DEPTH = 1 << PTR_WIDTH_DEF;
   typedef logic [PTR_WIDTH_DEF:0] ptr_t;
   function automatic ptr_t bin2gray(input ptr_t b);
      return (b >> 1) ^ b;
   endfunction
   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b[PTR_WIDTH_DEF] = g[PTR_WIDTH_DEF];
      for (int i = PTR_WIDTH_DEF - 1; i >= 0; i--) b[i] = b[i + 1] ^ g[i];
      return b;
   endfunction
endpackage

// File: rtl/rptr_handler_if.sv
// rptr_handler_if: read-side request, synchronised write pointer and status bundle
interface rptr_handler_if #(parameter int PTR_WIDTH = 3);
   logic rd_en;
   logic clr_err;
   logic [PTR_WIDTH:0] g_wptr_sync;
   logic [PTR_WIDTH:0] b_rptr;
   logic [PTR_WIDTH:0] g_rptr;
   logic [PTR_WIDTH:0] rd_level;
   logic empty;
   logic almost_empty;
   logic rd_valid;
   logic underflow;
   modport master (
      output rd_en, clr_err, g_wptr_sync,
      input b_rptr, g_rptr, rd_level, empty, almost_empty, rd_valid, underflow
   );
   modport slave (
      input rd_en, clr_err, g_wptr_sync,
      output b_rptr, g_rptr, rd_level, empty, almost_empty, rd_valid, underflow
   );
endinterface

// File: rtl/rptr_handler_gray2bin.sv
// rptr_handler_gray2bin: combinational Gray to binary conversion by prefix XOR from the MSB
module rptr_handler_gray2bin #(parameter int W = 4) (
   input  logic [W-1:0] gray,
   output logic [W-1:0] bin
);
   for (genvar i = 0; i < W; i++) begin : g_bit
      assign bin[i] = ^gray[W-1:i];
   end
endmodule

// File: rtl/rptr_handler.sv
// rptr_handler: read pointer, empty/level/almost-empty, read-valid and sticky underflow for an async FIFO
module rptr_handler
   import rptr_handler_pkg::*;
#(
   parameter int PTR_WIDTH = PTR_WIDTH_DEF,
   parameter int AE_THRESH = 1
) (
   input logic rclk,
   input logic rrst_n,
   rptr_handler_if.slave bus
);
   localparam logic [PTR_WIDTH:0] AE = AE_THRESH[PTR_WIDTH:0];
   logic rd_acc;
   logic [PTR_WIDTH:0] b_nxt, g_nxt, b_wptr_s, level_nxt;
   rptr_handler_gray2bin #(.W(PTR_WIDTH + 1)) u_g2b (
      .gray(bus.g_wptr_sync),
      .bin (b_wptr_s)
   );
   assign rd_acc = bus.rd_en & ~bus.empty;
   always_comb begin
      b_nxt     = bus.b_rptr + {{PTR_WIDTH{1'b0}}, rd_acc};
      g_nxt     = (b_nxt >> 1) ^ b_nxt;
      level_nxt = b_wptr_s - b_nxt;
   end
   // status looks at next-cycle pointers so empty asserts with the last read
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         bus.b_rptr       <= '0;
         bus.g_rptr       <= '0;
         bus.empty        <= 1'b1;
         bus.almost_empty <= 1'b1;
         bus.rd_level     <= '0;
         bus.rd_valid     <= 1'b0;
         bus.underflow    <= 1'b0;
      end else begin
         bus.b_rptr       <= b_nxt;
         bus.g_rptr       <= g_nxt;
         bus.empty        <= g_nxt == bus.g_wptr_sync;
         bus.almost_empty <= level_nxt <= AE;
         bus.rd_level     <= level_nxt;
         bus.rd_valid     <= rd_acc;
         bus.underflow    <= (bus.rd_en & bus.empty) | (bus.underflow & ~bus.clr_err);
      end
   end
endmodule

// File: tb/tb_rptr_handler.sv
// tb_rptr_handler: directed checks of reset, drain, underflow, async reset, full level and wrap
module tb_rptr_handler;
   logic rclk = 1'b0;
   logic rrst_n;
   int total = 0;
   int bad = 0;
   logic [3:0] gtab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                             4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
   int g_exp [5] = '{1, 3, 2, 6, 7};
   int ae_exp [5] = '{0, 0, 0, 1, 1};
   int chunk_tgt [4] = '{6, 12, 16, 19};
   rptr_handler_if #(.PTR_WIDTH(3)) bus ();
   rptr_handler #(.PTR_WIDTH(3), .AE_THRESH(1)) dut (
      .rclk(rclk),
      .rrst_n(rrst_n),
      .bus(bus)
   );
   always #5 rclk = ~rclk;
   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic step;
      @(posedge rclk);
      #1;
   endtask
   task automatic chk_reset(input string tag);
      chk({tag, "_b"}, int'(bus.b_rptr), 0);
      chk({tag, "_g"}, int'(bus.g_rptr), 0);
      chk({tag, "_empty"}, int'(bus.empty), 1);
      chk({tag, "_ae"}, int'(bus.almost_empty), 1);
      chk({tag, "_lvl"}, int'(bus.rd_level), 0);
      chk({tag, "_valid"}, int'(bus.rd_valid), 0);
      chk({tag, "_uf"}, int'(bus.underflow), 0);
   endtask
   initial begin
      int r, avail;
      rrst_n = 1'b0;
      bus.rd_en = 1'b0;
      bus.clr_err = 1'b0;
      bus.g_wptr_sync = 4'b0110;
      #12;
      chk_reset("rst");
      step();
      chk_reset("rst_edge");
      bus.g_wptr_sync = 4'b0000;
      rrst_n = 1'b1;
      step();
      chk("post_rst_empty", int'(bus.empty), 1);
      chk("post_rst_lvl", int'(bus.rd_level), 0);
      chk("post_rst_ae", int'(bus.almost_empty), 1);
      // fill to 5 then drain back to back
      bus.g_wptr_sync = 4'b0111;
      step();
      chk("fill_empty", int'(bus.empty), 0);
      chk("fill_lvl", int'(bus.rd_level), 5);
      chk("fill_ae", int'(bus.almost_empty), 0);
      bus.rd_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("drain_b", int'(bus.b_rptr), i + 1);
         chk("drain_g", int'(bus.g_rptr), g_exp[i]);
         chk("drain_valid", int'(bus.rd_valid), 1);
         chk("drain_lvl", int'(bus.rd_level), 4 - i);
         chk("drain_ae", int'(bus.almost_empty), ae_exp[i]);
         chk("drain_empty", int'(bus.empty), i == 4 ? 1 : 0);
      end
      bus.rd_en = 1'b0;
      step();
      chk("idle_valid", int'(bus.rd_valid), 0);
      chk("idle_b", int'(bus.b_rptr), 5);
      // underflow: set, hold, clear, simultaneous set-and-clear
      bus.rd_en = 1'b1;
      step();
      chk("uf_b", int'(bus.b_rptr), 5);
      chk("uf_g", int'(bus.g_rptr), 7);
      chk("uf_valid", int'(bus.rd_valid), 0);
      chk("uf_set", int'(bus.underflow), 1);
      bus.rd_en = 1'b0;
      step();
      chk("uf_hold", int'(bus.underflow), 1);
      bus.clr_err = 1'b1;
      step();
      chk("uf_clr", int'(bus.underflow), 0);
      bus.rd_en = 1'b1;
      step();
      chk("uf_set_wins", int'(bus.underflow), 1);
      chk("uf_b2", int'(bus.b_rptr), 5);
      bus.rd_en = 1'b0;
      bus.clr_err = 1'b0;
      // reset in the middle of a drain, between edges
      bus.g_wptr_sync = 4'b1111;
      step();
      chk("md_lvl", int'(bus.rd_level), 5);
      chk("md_empty", int'(bus.empty), 0);
      bus.rd_en = 1'b1;
      step();
      chk("md_b1", int'(bus.b_rptr), 6);
      step();
      chk("md_b2", int'(bus.b_rptr), 7);
      chk("md_lvl2", int'(bus.rd_level), 3);
      #2;
      rrst_n = 1'b0;
      #1;
      chk_reset("async_rst");
      bus.rd_en = 1'b0;
      bus.g_wptr_sync = 4'b0000;
      step();
      rrst_n = 1'b1;
      // full level reported as depth
      bus.g_wptr_sync = 4'b1100;
      step();
      chk("full_lvl", int'(bus.rd_level), 8);
      chk("full_empty", int'(bus.empty), 0);
      chk("full_ae", int'(bus.almost_empty), 0);
      bus.rd_en = 1'b1;
      step();
      chk("full_rd_lvl", int'(bus.rd_level), 7);
      chk("full_rd_b", int'(bus.b_rptr), 1);
      chk("full_rd_valid", int'(bus.rd_valid), 1);
      bus.rd_en = 1'b0;
      rrst_n = 1'b0;
      bus.g_wptr_sync = 4'b0000;
      step();
      rrst_n = 1'b1;
      // wrap: write pointer 6, 12, 16(0), 19(3), draining each chunk
      r = 0;
      for (int c = 0; c < 4; c++) begin
         avail = chunk_tgt[c] - r;
         bus.g_wptr_sync = gtab[chunk_tgt[c] % 16];
         step();
         chk("wrap_avail", int'(bus.rd_level), avail);
         chk("wrap_nempty", int'(bus.empty), 0);
         bus.rd_en = 1'b1;
         for (int k = 1; k <= avail; k++) begin
            step();
            r++;
            chk("wrap_b", int'(bus.b_rptr), r % 16);
            chk("wrap_msb", int'(bus.b_rptr[3]), (r % 16) >= 8 ? 1 : 0);
            chk("wrap_lvl", int'(bus.rd_level), avail - k);
            chk("wrap_lvl_le8", int'(bus.rd_level <= 4'd8), 1);
         end
         bus.rd_en = 1'b0;
         chk("wrap_chunk_empty", int'(bus.empty), 1);
      end
      chk("wrap_final_b", int'(bus.b_rptr), 3);
      chk("wrap_final_g", int'(bus.g_rptr), 2);
      chk("wrap_uf", int'(bus.underflow), 0);
      step();
      chk("wrap_final_empty", int'(bus.empty), 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
